mymodule_arbiter: RTL and testbench

- Shares one `mymodule`-style datapath between NUM_REQ requesters.
- Grants requests round-robin and drives the datapath through a registered valid/ready issue stage.
- Tracks the requester ID of every in-flight transaction in an ID FIFO, so in-order datapath responses are routed back to the originating requester.
- Sits between the requesting units and the single shared datapath instance.

---
 rtl/mymodule_arb_pkg.sv | 35 +++
 rtl/mymodule_arb_idfifo.sv | 61 ++++++
 rtl/mymodule_arbiter.sv | 116 +++++++++++
 tb/tb_mymodule_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mymodule_arb_pkg.sv
// Shared types and helpers for the round-robin datapath arbiter.
// Holds the ID-width helper, the issue-stage states and the round-robin picker.
package mymodule_arb_pkg;

    // Widest request vector rr_pick accepts; NUM_REQ must not exceed this.
    localparam int RR_MAX = 64;

    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } issue_state_e;

    // First set bit of valid at or above ptr, wrapping at n-1; returns ptr when none set.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
        int   win;
        int   idx;
        logic found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mymodule_arb_idfifo.sv
// Circular FIFO of requester IDs for in-flight transactions.
// Synchronous write, asynchronous read of the head; depth need not be a power of two.
module mymodule_arb_idfifo
    import mymodule_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_id,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ID_W(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mymodule_arbiter.sv
// Round-robin arbiter sharing one in-order datapath between NUM_REQ requesters.
// Registered issue stage toward the datapath; an ID FIFO routes responses back.
module mymodule_arbiter
    import mymodule_arb_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     dp_valid_o,
    output logic [WIDTH-1:0]         dp_data_o,
    input  logic                     dp_ready_i,
    input  logic                     dp_rsp_valid_i,
    input  logic [WIDTH-1:0]         dp_rsp_data_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]         rsp_data_o,
    output logic [CNT_W-1:0]         outstanding_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int IDW = ID_W(NUM_REQ);

    issue_state_e       state_q, state_d;
    logic [WIDTH-1:0]   issue_data_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     winner;
    logic               grant;
    logic               slot_free;

    logic               fifo_full;
    logic               fifo_empty;
    logic [IDW-1:0]     fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop_ok;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               err_q;

    // The issue slot frees up this cycle if it is empty or being accepted now.
    assign slot_free = (state_q == ST_EMPTY) || dp_ready_i;
    assign grant     = slot_free && !fifo_full && (|req_valid_i);
    assign winner    = IDW'(rr_pick(RR_MAX'(req_valid_i), int'(ptr_q), NUM_REQ));

    assign req_ready_o = grant ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant) state_d = ST_HOLD;
            ST_HOLD:  if (dp_ready_i && !grant) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_EMPTY;
            issue_data_q <= '0;
            ptr_q        <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                issue_data_q <= req_data_i[winner*WIDTH +: WIDTH];
                ptr_q        <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            end
        end
    end

    assign dp_valid_o = (state_q == ST_HOLD);
    assign dp_data_o  = issue_data_q;

    mymodule_arb_idfifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDW)
    ) u_idfifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (grant),
        .push_id (winner),
        .pop     (dp_rsp_valid_i),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pop_ok = dp_rsp_valid_i && !fifo_empty;

    // A response with nothing in flight has no owner: flag it and drop it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= pop_ok ? (NUM_REQ'(1) << fifo_head) : '0;
            if (pop_ok) rsp_data_q <= dp_rsp_data_i;
            if (dp_rsp_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign outstanding_o = fifo_count;
    assign busy_o        = (fifo_count != '0) || dp_valid_o;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mymodule_arbiter.sv
// Directed vector bench for mymodule_arbiter with default parameters (8-bit, 4 requesters, depth 4).
module tb_mymodule_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        dp_valid;
    logic [7:0]  dp_data;
    logic        dp_ready;
    logic        dp_rsp_valid;
    logic [7:0]  dp_rsp_data;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [2:0]  outstanding;
    logic        busy;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    mymodule_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_OUTSTANDING(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .dp_valid_o     (dp_valid),
        .dp_data_o      (dp_data),
        .dp_ready_i     (dp_ready),
        .dp_rsp_valid_i (dp_rsp_valid),
        .dp_rsp_data_i  (dp_rsp_data),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .outstanding_o  (outstanding),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        rdy;
        logic        rspv;
        logic [7:0]  rspd;
        logic [3:0]  e_rr;
        logic        e_dv;
        logic [7:0]  e_dd;
        logic [3:0]  e_rspv;
        logic [7:0]  e_rspd;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    localparam int NV = 28;
    localparam logic [31:0] D = 32'hA3A2A1A0;
    vec_t vecs[NV];

    function automatic vec_t mk(logic [3:0] rv, logic [31:0] rd, logic rdy, logic rspv,
                                logic [7:0] rspd, logic [3:0] e_rr, logic e_dv, logic [7:0] e_dd,
                                logic [3:0] e_rspv, logic [7:0] e_rspd, logic [2:0] e_out, logic e_err);
        vec_t v;
        v.rv = rv; v.rd = rd; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd;
        v.e_rr = e_rr; v.e_dv = e_dv; v.e_dd = e_dd; v.e_rspv = e_rspv;
        v.e_rspd = e_rspd; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    initial begin
        // rv, rd, rdy, rspv, rspd | e_rr, e_dv, e_dd, e_rspv, e_rspd, e_out, e_err
        vecs[0]  = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 0, 8'h00, 4'b0000, 8'h00, 0, 0);
        vecs[1]  = mk(4'b0001, 32'hA3A2A15A, 1, 0, 8'h00, 4'b0001, 0, 8'h00, 4'b0000, 8'h00, 0, 0);
        vecs[2]  = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 1, 8'h5A, 4'b0000, 8'h00, 1, 0);
        vecs[3]  = mk(4'b0000, D,            1, 1, 8'h11, 4'b0000, 0, 8'h5A, 4'b0000, 8'h00, 1, 0);
        vecs[4]  = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 0, 8'h5A, 4'b0001, 8'h11, 0, 0);
        vecs[5]  = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 0, 8'h5A, 4'b0000, 8'h11, 0, 0);
        // all requesting: pointer sits at 1, so 1,2,3,0 then full
        vecs[6]  = mk(4'b1111, D,            1, 0, 8'h00, 4'b0010, 0, 8'h5A, 4'b0000, 8'h11, 0, 0);
        vecs[7]  = mk(4'b1111, D,            1, 0, 8'h00, 4'b0100, 1, 8'hA1, 4'b0000, 8'h11, 1, 0);
        vecs[8]  = mk(4'b1111, D,            1, 0, 8'h00, 4'b1000, 1, 8'hA2, 4'b0000, 8'h11, 2, 0);
        vecs[9]  = mk(4'b1111, D,            1, 0, 8'h00, 4'b0001, 1, 8'hA3, 4'b0000, 8'h11, 3, 0);
        vecs[10] = mk(4'b1111, D,            1, 0, 8'h00, 4'b0000, 1, 8'hA0, 4'b0000, 8'h11, 4, 0);
        // full + pop in same cycle: no grant until the next cycle
        vecs[11] = mk(4'b1111, D,            1, 1, 8'h22, 4'b0000, 0, 8'hA0, 4'b0000, 8'h11, 4, 0);
        vecs[12] = mk(4'b1111, D,            1, 0, 8'h00, 4'b0010, 0, 8'hA0, 4'b0010, 8'h22, 3, 0);
        vecs[13] = mk(4'b0000, D,            1, 1, 8'h33, 4'b0000, 1, 8'hA1, 4'b0000, 8'h22, 4, 0);
        // grant and response together: occupancy unchanged
        vecs[14] = mk(4'b0100, D,            1, 1, 8'h44, 4'b0100, 0, 8'hA1, 4'b0100, 8'h33, 3, 0);
        vecs[15] = mk(4'b0000, D,            0, 0, 8'h00, 4'b0000, 1, 8'hA2, 4'b1000, 8'h44, 3, 0);
        // backpressure: held data stable, grant when ready rises
        vecs[16] = mk(4'b0001, D,            0, 0, 8'h00, 4'b0000, 1, 8'hA2, 4'b0000, 8'h44, 3, 0);
        vecs[17] = mk(4'b0001, D,            0, 0, 8'h00, 4'b0000, 1, 8'hA2, 4'b0000, 8'h44, 3, 0);
        vecs[18] = mk(4'b0001, D,            1, 0, 8'h00, 4'b0001, 1, 8'hA2, 4'b0000, 8'h44, 3, 0);
        vecs[19] = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 1, 8'hA0, 4'b0000, 8'h44, 4, 0);
        // drain: FIFO holds 0,1,2,0
        vecs[20] = mk(4'b0000, D,            1, 1, 8'h55, 4'b0000, 0, 8'hA0, 4'b0000, 8'h44, 4, 0);
        vecs[21] = mk(4'b0000, D,            1, 1, 8'h66, 4'b0000, 0, 8'hA0, 4'b0001, 8'h55, 3, 0);
        vecs[22] = mk(4'b0000, D,            1, 1, 8'h77, 4'b0000, 0, 8'hA0, 4'b0010, 8'h66, 2, 0);
        vecs[23] = mk(4'b0000, D,            1, 1, 8'h88, 4'b0000, 0, 8'hA0, 4'b0100, 8'h77, 1, 0);
        vecs[24] = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 0, 8'hA0, 4'b0001, 8'h88, 0, 0);
        // response with nothing in flight
        vecs[25] = mk(4'b0000, D,            1, 1, 8'h99, 4'b0000, 0, 8'hA0, 4'b0000, 8'h88, 0, 0);
        vecs[26] = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 0, 8'hA0, 4'b0000, 8'h88, 0, 1);
        vecs[27] = mk(4'b0000, D,            1, 0, 8'h00, 4'b0000, 0, 8'hA0, 4'b0000, 8'h88, 0, 1);

        rst_n = 1'b0; req_valid = '0; req_data = D; dp_ready = 1'b1;
        dp_rsp_valid = 1'b0; dp_rsp_data = '0;
        #1;
        chk("reset_dp_valid", -1, 32'(dp_valid), 0);
        chk("reset_outstanding", -1, 32'(outstanding), 0);
        chk("reset_busy", -1, 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req_valid = vecs[i].rv; req_data = vecs[i].rd; dp_ready = vecs[i].rdy;
            dp_rsp_valid = vecs[i].rspv; dp_rsp_data = vecs[i].rspd;
            #1;
            chk("req_ready", i, 32'(req_ready), 32'(vecs[i].e_rr));
            chk("dp_valid", i, 32'(dp_valid), 32'(vecs[i].e_dv));
            chk("dp_data", i, 32'(dp_data), 32'(vecs[i].e_dd));
            chk("rsp_valid", i, 32'(rsp_valid), 32'(vecs[i].e_rspv));
            chk("rsp_data", i, 32'(rsp_data), 32'(vecs[i].e_rspd));
            chk("outstanding", i, 32'(outstanding), 32'(vecs[i].e_out));
            chk("err", i, 32'(err), 32'(vecs[i].e_err));
            chk("busy", i, 32'(busy), 32'((vecs[i].e_out != 0) || vecs[i].e_dv));
        end

        // Asynchronous reset while an issue is held.
        @(negedge clk);
        req_valid = 4'b0010; dp_ready = 1'b1; dp_rsp_valid = 1'b0;
        #1 chk("hold_grant", 100, 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0000; dp_ready = 1'b0;
        #1 chk("hold_dp_valid", 101, 32'(dp_valid), 1);
        chk("hold_dp_data", 101, 32'(dp_data), 32'hA1);
        chk("hold_err_sticky", 101, 32'(err), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dp_valid", 102, 32'(dp_valid), 0);
        chk("arst_dp_data", 102, 32'(dp_data), 0);
        chk("arst_outstanding", 102, 32'(outstanding), 0);
        chk("arst_err", 102, 32'(err), 0);
        chk("arst_busy", 102, 32'(busy), 0);
        chk("arst_rsp_data", 102, 32'(rsp_data), 0);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'b1111; dp_ready = 1'b1;
        #1 chk("arst_ptr_zero", 103, 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1 chk("post_rst_issue", 104, 32'(dp_data), 32'hA0);
        chk("post_rst_out", 104, 32'(outstanding), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
